ultrasonic_sensor_model: RTL
============================

Name: ultrasonic_sensor_model

Overview:
- Synthesizable responder model of an HC-SR04-style ultrasonic ranging sensor. It is the far end of the trigger/echo interface driven by the ultrasonic ranging top (trigger out, echo in).
- Accepts a trigger pulse, waits a fixed burst delay, then drives an echo pulse whose width encodes a programmable distance in centimetres.
- Used in closed-loop simulation and on-board loopback, in place of the real sensor, for the ranging and 7-segment display path.

Parameters:
- TICKS_PER_US, 50, clk cycles per microsecond (50 MHz board clock).
- MIN_TRIG_US, 10, minimum trigger high width accepted, in µs.
- BURST_US, 200, delay from qualified trigger fall to echo rise (8 cycles × 40 kHz), in µs.
- US_PER_CM, 58, echo µs per centimetre of distance.
- MAX_CM, 200, largest distance that produces a valid echo.
- TIMEOUT_US, 38000, echo width for out-of-range distances, in µs.
- HOLDOFF_US, 1000, dead time after echo fall before re-arming, in µs.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset; synchronous, active-high.
- trig  in  1  trigger from the ranging controller.
- distance_cm  in  8  simulated target distance.
- echo  out  1  echo pulse to the ranging controller.
- busy  out  1  high while a measurement is in progress.
- short_trig  out  1  one-cycle pulse when a trigger is rejected as too short.
- meas_cm  out  8  distance latched for the current or last measurement.

Behaviour:
- Derived cycle counts:
  - T = MIN_TRIG_US·TICKS_PER_US
  - B = BURST_US·TICKS_PER_US
  - H = HOLDOFF_US·TICKS_PER_US
  - E = distance_cm·US_PER_CM·TICKS_PER_US when 1 ≤ distance_cm ≤ MAX_CM; otherwise E = TIMEOUT_US·TICKS_PER_US.
- Arithmetic: E is computed at latch time in a 32-bit unsigned product, with no truncation. The single down-counter is 32 bits. The trigger-width counter saturates at T; it never wraps.
- Edge detect: trig_q is registered trig. Rising edge = trig & ~trig_q; falling edge = ~trig & trig_q.
- Reset (clr sampled high): state IDLE, echo=0, busy=0, short_trig=0, meas_cm=0, counters=0, trig_q=1.
  - Because trig_q resets to 1, a trig held high through reset is ignored until it falls and rises again.
  - Reset mid-operation drops echo on that same edge.
- IDLE:
  - On a rising edge, go to TRIG with width count = 1.
  - busy=0.
- TRIG:
  - Increment the width count (saturating) each cycle trig is sampled high.
  - On a falling edge, if count ≥ T: latch meas_cm ← distance_cm, latch E, set busy=1, go to BURST with counter = B.
  - On a falling edge, if count < T: pulse short_trig for exactly 1 cycle and return to IDLE.
- BURST:
  - Decrement the counter. When it reaches 0, assert echo and go to ECHO with counter = E.
  - Echo therefore rises exactly B cycles after the clock edge that sampled trig low.
- ECHO:
  - echo stays high for exactly E cycles, then deasserts.
  - Go to HOLDOFF with counter = H.
- HOLDOFF:
  - Decrement the counter. At 0, clear busy and go to IDLE.
- Trig activity in BURST, ECHO or HOLDOFF is ignored: no restart, no short_trig. trig_q still tracks trig.
  - Consequently, if trig is already high on entry to IDLE, a new measurement needs a fresh rising edge.
- distance_cm changes after the latch do not affect the pulse in flight; meas_cm holds the latched value until the next qualified trigger.
- Boundary values of distance_cm:
  - distance_cm = 0 or > MAX_CM → timeout-width echo.
  - distance_cm = MAX_CM → normal width.
- Exactly one of the IDLE/TRIG/BURST/ECHO/HOLDOFF states is active.
- echo and busy are registered outputs, glitch-free.

Test Plan:
All scenarios use TICKS_PER_US=1, other parameters default, clk period 20 ns.
1. distance_cm=10, trig high 12 cycles → busy rises at the fall-detect edge; echo rises 200 cycles later, stays high 580 cycles; busy falls 1000 cycles after echo falls; meas_cm=10.
2. trig high 9 cycles → short_trig high for 1 cycle; echo and busy stay 0. Then trig high 10 cycles → accepted.
3. distance_cm=0, then 201, then 200 → echo widths 38000, 38000, 11600 cycles respectively.
4. distance_cm changed from 10 to 50 during ECHO, plus a 20-cycle trig pulse during BURST → current echo stays 580 cycles; no restart; the next qualified trigger yields 2900 cycles.
5. clr asserted 100 cycles into ECHO → echo=0, busy=0 on that edge. trig held high through reset release → no measurement until trig falls and re-rises ≥10 cycles.
6. Back-to-back triggers issued as soon as busy falls, distance_cm=1 → each echo is exactly 58 cycles; spacing is consistent.

Source files
------------

// File: rtl/ultrasonic_sensor_model.sv
// Responder model of an HC-SR04-style ultrasonic ranging sensor.
// A qualified trigger pulse is followed by a fixed burst delay, then an echo
// pulse whose width encodes the programmed distance (or a timeout width when
// the distance is out of range). A hold-off period follows each echo.
module ultrasonic_sensor_model #(
    parameter int unsigned TICKS_PER_US = 50,
    parameter int unsigned MIN_TRIG_US  = 10,
    parameter int unsigned BURST_US     = 200,
    parameter int unsigned US_PER_CM    = 58,
    parameter int unsigned MAX_CM       = 200,
    parameter int unsigned TIMEOUT_US   = 38000,
    parameter int unsigned HOLDOFF_US   = 1000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       trig,
    input  logic [7:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       short_trig,
    output logic [7:0] meas_cm
);

    // Cycle counts derived from the timing parameters
    localparam logic [31:0] T_CYC    = 32'(MIN_TRIG_US * TICKS_PER_US);
    localparam logic [31:0] B_CYC    = 32'(BURST_US * TICKS_PER_US);
    localparam logic [31:0] H_CYC    = 32'(HOLDOFF_US * TICKS_PER_US);
    localparam logic [31:0] CM_CYC   = 32'(US_PER_CM * TICKS_PER_US);
    localparam logic [31:0] TMO_CYC  = 32'(TIMEOUT_US * TICKS_PER_US);
    localparam logic [31:0] MAX_DIST = 32'(MAX_CM);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRIG    = 3'd1;
    localparam logic [2:0] S_BURST   = 3'd2;
    localparam logic [2:0] S_ECHO    = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    logic [2:0]  r_state;
    logic        r_trig_q;
    logic [31:0] r_wcnt;     // trigger high-width count, saturates at T_CYC
    logic [31:0] r_cnt;      // shared down-counter for burst/echo/hold-off
    logic [31:0] r_elen;     // echo width latched with the measurement
    logic        r_echo;
    logic        r_busy;
    logic        r_short;
    logic [7:0]  r_meas;

    logic        w_rise;
    logic        w_fall;
    logic [31:0] w_dist;
    logic        w_dist_ok;
    logic [31:0] w_elen;

    assign w_rise    = trig & ~r_trig_q;
    assign w_fall    = ~trig & r_trig_q;
    assign w_dist    = {24'd0, distance_cm};
    assign w_dist_ok = (w_dist != 32'd0) && (w_dist <= MAX_DIST);
    // Full 32-bit product: 255 cm at 50 ticks/us still fits comfortably
    assign w_elen    = w_dist_ok ? (w_dist * CM_CYC) : TMO_CYC;

    assign echo       = r_echo;
    assign busy       = r_busy;
    assign short_trig = r_short;
    assign meas_cm    = r_meas;

    // Measurement sequencer: trigger qualify, burst delay, echo, hold-off
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= S_IDLE;
            r_trig_q <= 1'b1;   // a trig held through reset needs a fresh rise
            r_wcnt   <= 32'd0;
            r_cnt    <= 32'd0;
            r_elen   <= 32'd0;
            r_echo   <= 1'b0;
            r_busy   <= 1'b0;
            r_short  <= 1'b0;
            r_meas   <= 8'd0;
        end else begin
            r_trig_q <= trig;
            r_short  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_rise) begin
                        r_wcnt  <= 32'd1;
                        r_state <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    if (w_fall) begin
                        if (r_wcnt >= T_CYC) begin
                            r_meas  <= distance_cm;
                            r_elen  <= w_elen;
                            r_busy  <= 1'b1;
                            r_cnt   <= B_CYC;
                            r_state <= S_BURST;
                        end else begin
                            r_short <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else if (trig && (r_wcnt < T_CYC)) begin
                        r_wcnt <= r_wcnt + 32'd1;
                    end
                end
                // Count lands on 1 at the B-th edge so echo rises exactly B after fall-detect
                S_BURST: begin
                    if (r_cnt <= 32'd1) begin
                        r_echo  <= 1'b1;
                        r_cnt   <= r_elen;
                        r_state <= S_ECHO;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_ECHO: begin
                    if (r_cnt <= 32'd1) begin
                        r_echo  <= 1'b0;
                        r_cnt   <= H_CYC;
                        r_state <= S_HOLDOFF;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_HOLDOFF: begin
                    if (r_cnt <= 32'd1) begin
                        r_busy  <= 1'b0;
                        r_cnt   <= 32'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                default: begin
                    r_echo  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
